// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode handshake and redirect.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            misalign_trap;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_trap,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect,
           redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misalign_trap,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect,
           redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC register, single-outstanding fetch FSM, redirect squash.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StTrap} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [31:0]     instr_q;
  logic            drop_q;
  logic [XLEN-1:0] target;
  logic            misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target            = bus.redirect_target;
  assign misaligned        = |bus.redirect_target[1:0];
  assign bus.misalign_trap = (state_q == StTrap);
`else
  logic unused_tgt_bits;
  assign unused_tgt_bits   = ^bus.redirect_target[1:0];
  assign target            = {bus.redirect_target[XLEN-1:2], 2'b00};
  assign misaligned        = 1'b0;
  assign bus.misalign_trap = 1'b0;
`endif

  assign bus.imem_req_valid = (state_q == StReq);
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = (state_q == StHold);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      instr_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      drop_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          if (bus.redirect) begin
            pc_q   <= target;
            // A request accepted alongside the redirect carries the stale PC.
            drop_q <= bus.imem_req_ready;
            if (misaligned) begin
              state_q <= StTrap;
            end else if (bus.imem_req_ready) begin
              state_q <= StWait;
            end
          end else if (bus.imem_req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.redirect) begin
            pc_q   <= target;
            drop_q <= !bus.imem_rsp_valid;
            if (misaligned) begin
              state_q <= StTrap;
            end else if (bus.imem_rsp_valid) begin
              state_q <= StReq;
            end
          end else if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              instr_q    <= bus.imem_rsp_data;
              instr_pc_q <= pc_q;
              state_q    <= StHold;
            end
          end
        end
        StHold: begin
          if (bus.redirect) begin
            pc_q    <= target;
            instr_q <= NOP_INSTR;
            state_q <= misaligned ? StTrap : StReq;
          end else if (bus.instr_ready) begin
            pc_q    <= pc_q + XLEN'(4);
            instr_q <= NOP_INSTR;
            state_q <= StReq;
          end
        end
        StTrap: begin
          // Absorb any response still owed from before the trap.
          if (bus.imem_rsp_valid) begin
            drop_q <= 1'b0;
          end
          if (bus.redirect) begin
            pc_q <= target;
            if (!misaligned) begin
              state_q <= (drop_q && !bus.imem_rsp_valid) ? StWait : StReq;
            end
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;
  localparam int unsigned XLEN    = 32;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (ResetPc),
    .NOP_INSTR(Nop)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: next address the program should fetch, expected trap flag, memory side.
  logic [31:0] exp_next = ResetPc;
  logic        exp_trap = 1'b0;
  logic        pending  = 1'b0;
  logic [31:0] pend_addr;
  int          lat_cnt;
  int          cyc = 0, idle = 0, deliveries = 0;
  logic        stray = 1'b0;

  int          p_ready = 100, p_iready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  int          redir_mode = 0;
  logic [31:0] redir_tgt;
  logic        redir_fired;

  logic        s_rv, s_iv, s_trap;
  logic [31:0] s_addr, s_instr, s_ipc;

  logic [31:0] acc_addr[$];
  int          acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom & 32'h0000_0FFC;
    if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3));
    if ($urandom_range(15) == 0) t = t | 32'hFFFF_F000;
    return t;
  endfunction

  // One clock: sample at negedge, drive inputs, advance the model over the next posedge.
  task automatic cycle();
    logic        rdy, rsp, irdy, rdr;
    logic [31:0] tgt, rdata;
    @(negedge clk);
    cyc++;
    s_rv    = bus.imem_req_valid;
    s_addr  = bus.imem_req_addr;
    s_iv    = bus.instr_valid;
    s_instr = bus.instr;
    s_ipc   = bus.instr_pc;
    s_trap  = bus.misalign_trap;

    rdy   = ($urandom_range(99) < p_ready);
    rsp   = 1'b0;
    rdata = $urandom;
    if (stray) begin
      rsp   = 1'b1;
      rdata = 32'hDEAD_BEEF;
      rdy   = 1'b0;
      stray = 1'b0;
    end else if (pending) begin
      if (lat_cnt == 0) begin
        rsp   = 1'b1;
        rdata = memf(pend_addr);
      end else begin
        lat_cnt--;
      end
    end
    irdy = ($urandom_range(99) < p_iready);
    rdr  = ($urandom_range(99) < p_redir);
    tgt  = rand_target();
    if (redir_mode == 1 || (redir_mode == 2 && s_iv) || (redir_mode == 3 && pending && !rsp)) begin
      rdr         = 1'b1;
      tgt         = redir_tgt;
      redir_mode  = 0;
      redir_fired = 1'b1;
    end

    bus.imem_req_ready  = rdy;
    bus.imem_rsp_valid  = rsp;
    bus.imem_rsp_data   = rdata;
    bus.instr_ready     = irdy;
    bus.redirect        = rdr;
    bus.redirect_target = tgt;

    if (!s_iv) check("instr_nop_idle", s_instr, Nop);
    if (s_iv) check("instr_data", s_instr, memf(s_ipc));
    check("misalign_trap", s_trap, exp_trap);
    if (s_rv) check("one_outstanding", pending, 0);
    if (exp_trap) check("trap_noreq", s_rv, 0);

    if (rsp) pending = 1'b0;
    if (s_rv && rdy) begin
      check("req_addr", s_addr, exp_next);
      pending   = 1'b1;
      pend_addr = s_addr;
      lat_cnt   = $urandom_range(lat_max, lat_min) - 1;
      acc_addr.push_back(s_addr);
      acc_cyc.push_back(cyc);
      idle = 0;
    end
    if (s_iv && irdy && !rdr) begin
      check("instr_pc", s_ipc, exp_next);
      exp_next = exp_next + 32'd4;
      deliveries++;
      idle = 0;
    end
    if (rdr) begin
      exp_next = TrapEn ? tgt : {tgt[31:2], 2'b00};
      exp_trap = TrapEn && (tgt[1:0] != 2'b00);
      idle     = 0;
    end
    idle++;
    if (idle > 60) begin
      check("stall", idle, 0);
      idle = 0;
    end
  endtask

  task automatic run_until_acc(input int n, input int budget);
    int k = 0;
    acc_addr.delete();
    acc_cyc.delete();
    while (acc_addr.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check("acc_timeout", acc_addr.size(), n);
  endtask

  task automatic fire_redirect(input int mode, input logic [31:0] tgt, input int budget);
    int k = 0;
    redir_mode  = mode;
    redir_tgt   = tgt;
    redir_fired = 1'b0;
    while (!redir_fired && k < budget) begin
      cycle();
      k++;
    end
    check("redir_fired", redir_fired, 1);
    redir_mode = 0;
  endtask

  task automatic check_reset();
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_req_addr", bus.imem_req_addr, ResetPc);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, Nop);
    check("rst_instr_pc", bus.instr_pc, ResetPc);
    check("rst_trap", bus.misalign_trap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] h_instr, h_pc;
    int          k;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    #12;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back fetch, ready memory, 1-cycle latency.
    run_until_acc(3, 40);
    if (acc_addr.size() >= 3) begin
      check("seq_addr0", acc_addr[0], 32'h0);
      check("seq_addr1", acc_addr[1], 32'h4);
      check("seq_addr2", acc_addr[2], 32'h8);
      check("seq_gap01", acc_cyc[1] - acc_cyc[0], 3);
      check("seq_gap12", acc_cyc[2] - acc_cyc[1], 3);
    end

    // Decode stall in HOLD.
    p_iready = 0;
    k = 0;
    while (!s_iv && k < 30) begin
      cycle();
      k++;
    end
    check("hold_seen", s_iv, 1);
    h_instr = s_instr;
    h_pc    = s_ipc;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_instr", s_instr, h_instr);
      check("hold_pc", s_ipc, h_pc);
      check("hold_noreq", s_rv, 0);
    end
    p_iready = 100;
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("hold_advance", acc_addr[0], h_pc + 32'd4);

    // Redirect while waiting on a 3-cycle response.
    lat_min = 3;
    lat_max = 3;
    fire_redirect(3, 32'h100, 40);
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("redir_wait", acc_addr[0], 32'h100);

    // Redirect coincident with the decode handshake.
    lat_min = 1;
    lat_max = 1;
    fire_redirect(2, 32'h200, 40);
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("redir_handshake", acc_addr[0], 32'h200);

    // Misaligned redirect.
    fire_redirect(1, 32'h102, 5);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("trap_held", s_trap, 1);
    end
    fire_redirect(1, 32'h300, 5);
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("trap_exit", acc_addr[0], 32'h300);
`else
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("misalign_forced", acc_addr[0], 32'h100);
`endif

    // PC wraps past the top of the address space.
    fire_redirect(1, 32'hFFFF_FFFC, 5);
    run_until_acc(2, 40);
    if (acc_addr.size() >= 2) begin
      check("wrap_top", acc_addr[0], 32'hFFFF_FFFC);
      check("wrap_zero", acc_addr[1], 32'h0);
    end

    // Asynchronous reset in WAIT, then a stray response.
    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (!pending && k < 40) begin
      cycle();
      k++;
    end
    check("wait_reached", pending, 1);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    pending  = 1'b0;
    exp_next = ResetPc;
    exp_trap = 1'b0;
    idle     = 0;
    @(negedge clk);
    rst_n               = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b1;
    bus.imem_rsp_data   = 32'hDEAD_BEEF;
    bus.redirect        = 1'b0;
    stray               = 1'b1;
    run_until_acc(1, 40);
    if (acc_addr.size() >= 1) check("post_reset_addr", acc_addr[0], ResetPc);

    // Random traffic.
    p_ready  = 60;
    p_iready = 60;
    p_redir  = 8;
    lat_min  = 1;
    lat_max  = 4;
    for (int i = 0; i < 1500; i++) cycle();
    check("progress", deliveries > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
